// File: rtl/i_arb_pkg.sv
// i_arb_pkg: shared interconnect definitions for the i_arb two-port packet arbiter.
// Holds the FSM state encoding, the header route field bounds and the buffer beat layout.
package i_arb_pkg;

  localparam int DATA_W   = 64;
  // Buffer beat layout: {TLAST, unused, TDATA}
  localparam int BEAT_W   = 66;
  localparam int ROUTE_HI = 55;
  localparam int ROUTE_LO = 48;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  // Shift the source port index into the LSB of the route field; the route MSB falls off.
  function automatic logic [DATA_W-1:0] insert_route(input logic [DATA_W-1:0] data,
                                                     input logic              port);
    logic [DATA_W-1:0] r;
    r = data;
    r[ROUTE_HI:ROUTE_LO] = {data[ROUTE_HI-1:ROUTE_LO], port};
    return r;
  endfunction

endpackage

// File: rtl/arb_skid_buf.sv
// arb_skid_buf: 2-entry valid/ready FIFO used as the i_arb output buffer.
// in_ready is held low while rst is asserted so nothing is accepted during reset.
module arb_skid_buf
  import i_arb_pkg::*;
#(
  parameter int W = BEAT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push, pop;

  assign in_ready  = ~rst & (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Next storage, pointers and occupancy from this cycle's push/pop
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  // Buffer registers; reset empties the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/i_arb.sv
// i_arb: two-input packet arbiter merging whole packets onto one output stream.
// Alternating priority between ports, optional route-field insertion (ADD_ROUTE),
// per-port grant counters built only when I_ARB_STATS_EN is defined.
module i_arb
  import i_arb_pkg::*;
#(
  parameter int ADD_ROUTE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              I0_TVALID,
  output logic              I0_TREADY,
  input  logic [DATA_W-1:0] I0_TDATA,
  input  logic              I0_TLAST,
  input  logic              I1_TVALID,
  output logic              I1_TREADY,
  input  logic [DATA_W-1:0] I1_TDATA,
  input  logic              I1_TLAST,
  output logic              O_TVALID,
  input  logic              O_TREADY,
  output logic [DATA_W-1:0] O_TDATA,
  output logic              O_TLAST,
  output logic [CNT_W-1:0]  GNT0_CNT,
  output logic [CNT_W-1:0]  GNT1_CNT
);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              sel, sel_en;
  logic              buf_ready;
  logic              acc_valid, acc_last, accept, hdr_accept;
  logic [DATA_W-1:0] acc_data, fwd_data;
  logic [BEAT_W-1:0] buf_in, buf_out;
  logic              unused_pad;

  // Port selection, handshake and next state
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel          = 1'b0;
    sel_en       = 1'b0;
    case (state_q)
      IDLE: begin
        sel_en = I0_TVALID | I1_TVALID;
        sel    = (I0_TVALID & I1_TVALID) ? ~last_grant_q : I1_TVALID;
      end
      LOCK0: begin
        sel_en = 1'b1;
        sel    = 1'b0;
      end
      LOCK1: begin
        sel_en = 1'b1;
        sel    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    acc_valid  = sel ? I1_TVALID : I0_TVALID;
    acc_last   = sel ? I1_TLAST  : I0_TLAST;
    acc_data   = sel ? I1_TDATA  : I0_TDATA;
    accept     = sel_en & acc_valid & buf_ready;
    hdr_accept = accept & (state_q == IDLE);
    if (hdr_accept) begin
      last_grant_d = sel;
      if (!acc_last) begin
        state_d = sel ? LOCK1 : LOCK0;
      end
    end else if (accept && acc_last) begin
      state_d = IDLE;
    end
  end

  assign I0_TREADY = buf_ready & sel_en & ~sel;
  assign I1_TREADY = buf_ready & sel_en & sel;

  // Header route rewrite; every other beat passes untouched
  always_comb begin
    fwd_data = acc_data;
    if ((ADD_ROUTE != 0) && (state_q == IDLE)) begin
      fwd_data = insert_route(acc_data, sel);
    end
  end

  assign buf_in = {acc_last, 1'b0, fwd_data};

  // Arbiter state; port 0 wins the first contested header after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  arb_skid_buf #(
    .W(BEAT_W)
  ) u_buf (
    .clk      (clk),
    .rst      (reset),
    .in_valid (sel_en & acc_valid),
    .in_ready (buf_ready),
    .in_data  (buf_in),
    .out_valid(O_TVALID),
    .out_ready(O_TREADY),
    .out_data (buf_out)
  );

  assign O_TLAST    = buf_out[BEAT_W-1];
  assign O_TDATA    = buf_out[DATA_W-1:0];
  assign unused_pad = buf_out[DATA_W];

`ifdef I_ARB_STATS_EN
  logic [CNT_W-1:0] gnt0_cnt_q, gnt0_cnt_d;
  logic [CNT_W-1:0] gnt1_cnt_q, gnt1_cnt_d;

  // Count accepted headers per port, wrapping naturally
  always_comb begin
    gnt0_cnt_d = gnt0_cnt_q;
    gnt1_cnt_d = gnt1_cnt_q;
    if (hdr_accept) begin
      if (sel) gnt1_cnt_d = gnt1_cnt_q + CNT_W'(1);
      else     gnt0_cnt_d = gnt0_cnt_q + CNT_W'(1);
    end
  end

  // Grant counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt0_cnt_q <= '0;
      gnt1_cnt_q <= '0;
    end else begin
      gnt0_cnt_q <= gnt0_cnt_d;
      gnt1_cnt_q <= gnt1_cnt_d;
    end
  end

  assign GNT0_CNT = gnt0_cnt_q;
  assign GNT1_CNT = gnt1_cnt_q;
`else
  assign GNT0_CNT = '0;
  assign GNT1_CNT = '0;
`endif

endmodule
